tick_gen: RTL
=============

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: per-channel counter and final-value width.
REQ-002 SHALL have parameter NCH, default 4: number of independent tick channels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, NCH bits: per-channel count enable.
REQ-006 SHALL have port final_value, input, NCH*WIDTH bits: channel i terminal count in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port load, input, NCH bits: per-channel restart strobe.
REQ-008 SHALL have port oneshot, input, NCH bits: per-channel mode select (1 = one-shot, 0 = periodic).
REQ-009 SHALL have port done, output, NCH bits: per-channel registered one-cycle tick pulse.
REQ-010 SHALL have port busy, output, NCH bits: channel counting (enable high and channel armed).
REQ-011 SHALL have port count, output, NCH*WIDTH bits: current counter value of each channel, same packing as final_value.

Function
REQ-012 Each channel SHALL hold a WIDTH-bit counter q, an armed flag and a registered done bit; channels SHALL be fully independent.
REQ-013 Per edge, priority SHALL be: load, then enable, then hold.
REQ-014 On load[i]=1: q<=0, done[i]<=0, armed<=1, regardless of enable[i].
REQ-015 With enable[i]=1, armed=1 and q<final_value: q<=q+1, done[i]<=0.
REQ-016 With enable[i]=1, armed=1 and q>=final_value: q<=0, done[i]<=1 for exactly the next cycle.
REQ-017 The >= compare SHALL be used so that lowering final_value below the current q wraps on the next enabled edge, with no run to 2^WIDTH-1.
REQ-018 Periodic mode SHALL give a tick period of final_value+1 enabled cycles.
REQ-019 final_value=0 in periodic mode SHALL hold done[i] high continuously while enabled.
REQ-020 With enable[i]=0: q SHALL hold and done[i] SHALL be 0 next cycle; counting SHALL resume from the held q.
REQ-021 In one-shot mode, the wrap edge SHALL also clear armed; the counter SHALL then hold at 0 and produce no further done until load[i].
REQ-022 busy[i] SHALL equal enable[i] AND armed, combinationally.
REQ-023 count SHALL reflect the registered q directly.
REQ-024 A change of oneshot[i] SHALL take effect at the next wrap only.

Reset
REQ-025 reset_n=0 SHALL, asynchronously: set q=0 and done=0 on all channels, and set armed=1 on all channels.
REQ-026 Reset asserted mid-count SHALL discard the count; after release, the first enabled edge SHALL increment from 0.
REQ-027 No output SHALL pulse on the reset release edge.

Configuration
REQ-028 Macro TICK_GEN_ONESHOT_EN defined: one-shot mode (REQ-021) SHALL be implemented as specified.
REQ-029 Macro TICK_GEN_ONESHOT_EN undefined: the oneshot input SHALL be ignored, all channels SHALL be periodic, and armed SHALL be constant 1 (busy = enable).

Verification
REQ-030 WIDTH=8, ch0 final_value=4, enable held high, periodic -> done[0] pulses one cycle every 5 cycles; count sequence 0,1,2,3,4,0.
REQ-031 ch1 final_value=0, enabled -> done[1] constantly high; enable low one cycle -> done[1] low that next cycle only.
REQ-032 ch2 one-shot (TICK_GEN_ONESHOT_EN defined), final_value=3 -> single done after 4 cycles; busy low and count=0 thereafter; load -> busy high and next done after 4 more cycles.
REQ-033 ch3 count reaches 9 with final_value=20, then final_value changed to 5 -> wrap and done on the next edge; next period is 6 cycles.
REQ-034 Assert reset_n low asynchronously mid-count at q=7 -> count=0 and done=0 immediately, before the next clock edge; after release, count increments from 0.
REQ-035 Simultaneous load[0] and wrap condition on ch0 -> load wins: q=0, done[0]=0; other channels unaffected.

Source files
------------

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen: NCH independent programmable tick channels.
//
// Each channel holds a WIDTH-bit counter q, an armed flag and a registered
// done bit. On every rising edge of clk, each channel applies the first rule
// that matches:
//   1. load: restart the channel.
//   2. enable while armed: count up, or wrap and raise done.
//   3. otherwise: hold q and clear done.
//
// The terminal compare uses q >= final_value. Lowering final_value below the
// running count therefore wraps on the next enabled edge, so the counter does
// not run on to its all-ones value.
//
// Optional feature macro: TICK_GEN_ONESHOT_EN
//   defined   : oneshot[i]=1 clears armed on the wrap edge. The channel then
//               parks at 0 until it sees a load.
//   undefined : every channel is periodic, the oneshot input is ignored,
//               armed is constant 1, and busy equals enable.
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCH-1:0]         enable,
    input  logic [NCH*WIDTH-1:0]   final_value,
    input  logic [NCH-1:0]         load,
    input  logic [NCH-1:0]         oneshot,
    output logic [NCH-1:0]         done,
    output logic [NCH-1:0]         busy,
    output logic [NCH*WIDTH-1:0]   count
);

    // Per-channel state. The packed layout matches the flat bus packing, so
    // channel i occupies bits [i*WIDTH +: WIDTH].
    logic [NCH-1:0][WIDTH-1:0] q_r;
    logic [NCH-1:0][WIDTH-1:0] q_nxt_s;
    logic [NCH-1:0][WIDTH-1:0] fv_s;
    logic [NCH-1:0]            done_r;
    logic [NCH-1:0]            done_nxt_s;
    logic [NCH-1:0]            armed_s;
    logic [NCH-1:0]            wrap_s;

    assign fv_s = final_value;

    // Wrap qualifier: the channel is counting and has reached or passed its
    // terminal value.
    always_comb begin
        wrap_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (enable[i] && armed_s[i] && (q_r[i] >= fv_s[i])) begin
                wrap_s[i] = 1'b1;
            end else begin
                wrap_s[i] = 1'b0;
            end
        end
    end

    // Counter and done next-state logic. Load beats enable, and enable beats
    // hold. The done bit is cleared on every edge that is not a wrap edge.
    always_comb begin
        q_nxt_s    = q_r;
        done_nxt_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (load[i]) begin
                q_nxt_s[i]    = {WIDTH{1'b0}};
                done_nxt_s[i] = 1'b0;
            end else if (enable[i] && armed_s[i]) begin
                if (wrap_s[i]) begin
                    q_nxt_s[i]    = {WIDTH{1'b0}};
                    done_nxt_s[i] = 1'b1;
                end else begin
                    q_nxt_s[i]    = q_r[i] + WIDTH'(1'b1);
                    done_nxt_s[i] = 1'b0;
                end
            end else begin
                q_nxt_s[i]    = q_r[i];
                done_nxt_s[i] = 1'b0;
            end
        end
    end

    // Counter and done registers. Reset clears them asynchronously, so no
    // pulse can appear on the release edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r    <= {(NCH*WIDTH){1'b0}};
            done_r <= {NCH{1'b0}};
        end else begin
            q_r    <= q_nxt_s;
            done_r <= done_nxt_s;
        end
    end

`ifdef TICK_GEN_ONESHOT_EN
    logic [NCH-1:0] armed_r;
    logic [NCH-1:0] armed_nxt_s;

    // Armed next-state logic. Load re-arms the channel. A wrap disarms it
    // when oneshot is set at that wrap edge, which means a change of mode
    // only matters at the next wrap.
    always_comb begin
        armed_nxt_s = armed_r;
        for (int i = 0; i < NCH; i++) begin
            if (load[i]) begin
                armed_nxt_s[i] = 1'b1;
            end else if (wrap_s[i] && oneshot[i]) begin
                armed_nxt_s[i] = 1'b0;
            end else begin
                armed_nxt_s[i] = armed_r[i];
            end
        end
    end

    // Armed register. Reset leaves every channel armed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_r <= {NCH{1'b1}};
        end else begin
            armed_r <= armed_nxt_s;
        end
    end

    assign armed_s = armed_r;
`else
    // Periodic-only build: channels are permanently armed and the mode
    // select is not used. The reduction gives the input a named sink.
    logic oneshot_unused_s;

    assign armed_s          = {NCH{1'b1}};
    assign oneshot_unused_s = ^oneshot;
`endif

    assign done  = done_r;
    assign busy  = enable & armed_s;
    assign count = q_r;

endmodule
